// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory reads and holds one fetched
// instruction for decode. Define IFU_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign,
  output logic [1:0]  dbg_state
);

  // Handshake: the slot transfers to decode on a cycle where if_valid && if_ready;
  // if_valid, if_pc and if_instr do not change while if_valid && !if_ready, except on redirect/reset.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        can_accept;
  logic        complete;
  logic        redirect_take;
  logic        target_misaligned;
  logic [31:0] redirect_target;

`ifdef IFU_MISALIGN_TRAP_EN
  assign target_misaligned = |redirect_pc[1:0];
  assign redirect_target   = redirect_pc;
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign target_misaligned   = 1'b0;
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
`endif

  assign can_accept    = !if_valid || if_ready;
  assign imem_req      = (state == RUN) && can_accept;
  assign imem_addr     = pc;
  assign complete      = imem_req && imem_ready && !redirect_valid;
  assign redirect_take = redirect_valid && (state != IDLE);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = RUN;
      RUN, TRAP: if (redirect_valid) state_nxt = target_misaligned ? TRAP : RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  // Redirect outranks completion and drain; rdata arriving with a redirect is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= 32'h0;
      if_pc    <= 32'h0;
      misalign <= 1'b0;
    end else if (redirect_take) begin
      if_valid <= 1'b0;
      pc       <= redirect_target;
      misalign <= target_misaligned;
    end else if (complete) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
      pc       <= pc + 32'd4;
    end else if (if_valid && if_ready) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle table, hand sequences for redirect/trap/wrap/reset,
// and a randomized run scored against an expected-PC stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0004;
  localparam logic [31:0] XORPAT = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  // Memory model: every word reads as its address xor a fixed pattern.
  assign imem_rdata = imem_addr ^ XORPAT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        if_rdy;
    logic        mem_rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_v;
  logic        hold_pending;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  int          accepts;

  initial begin
    // Each row: inputs during one cycle, outputs expected in that cycle.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h04, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0C, 1'b1, 32'h08};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0C, 1'b1, 32'h08};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0C, 1'b1, 32'h08};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 1'b1, 32'h10};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h24, 1'b1, 32'h20};

    reset = 1'b1; if_ready = 1'b1; imem_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if_ready       = vecs[i].if_rdy;
      imem_ready     = vecs[i].mem_rdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk1($sformatf("row%0d_req", i), imem_req, vecs[i].exp_req);
      chk32($sformatf("row%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk1($sformatf("row%0d_valid", i), if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk32($sformatf("row%0d_pc", i), if_pc, vecs[i].exp_pc);
        chk32($sformatf("row%0d_instr", i), if_instr, vecs[i].exp_pc ^ XORPAT);
      end
      if (i == 0) begin
        chk32("reset_instr", if_instr, 32'h0);
        chk32("reset_pc", if_pc, 32'h0);
        chk1("reset_misalign", misalign, 1'b0);
      end
      tick();
    end
    redirect_valid = 1'b0;
    if_ready = 1'b1; imem_ready = 1'b1;

    // Misaligned redirect target 0x22.
    redirect_to(32'h22);
`ifdef IFU_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk1("trap_misalign", misalign, 1'b1);
      chk1("trap_req", imem_req, 1'b0);
      chk1("trap_valid", if_valid, 1'b0);
      tick();
    end
    chk32("trap_addr", imem_addr, 32'h22);
    redirect_to(32'h26);
    chk1("trap_remis", misalign, 1'b1);
    chk1("trap_remis_req", imem_req, 1'b0);
`else
    chk1("mis_req", imem_req, 1'b1);
    chk32("mis_addr", imem_addr, 32'h20);
    chk1("mis_flag", misalign, 1'b0);
    tick();
    chk1("mis_valid", if_valid, 1'b1);
    chk32("mis_pc", if_pc, 32'h20);
`endif
    redirect_to(32'h40);
    chk1("r40_misalign", misalign, 1'b0);
    chk1("r40_req", imem_req, 1'b1);
    chk32("r40_addr", imem_addr, 32'h40);
    tick();
    chk1("r40_valid", if_valid, 1'b1);
    chk32("r40_pc", if_pc, 32'h40);

    // PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    chk32("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    chk1("wrap_valid0", if_valid, 1'b0);
    tick();
    chk32("wrap_pc1", if_pc, 32'hFFFF_FFFC);
    chk32("wrap_addr1", imem_addr, 32'h0);
    tick();
    chk32("wrap_pc2", if_pc, 32'h0);
    chk32("wrap_instr2", if_instr, XORPAT);

    // Reset mid-operation, then a redirect during IDLE must be ignored.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    #1;
    chk1("mreset_valid", if_valid, 1'b0);
    chk1("mreset_req", imem_req, 1'b0);
    chk32("mreset_addr", imem_addr, RST_PC);
    chk32("mreset_pc", if_pc, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk1("idle_redir_req", imem_req, 1'b1);
    chk32("idle_redir_addr", imem_addr, RST_PC);

    // Randomized run: accepted PCs must follow the expected stream, restarting at each redirect.
    exp_q.delete();
    exp_q.push_back(RST_PC);
    hold_pending = 1'b0;
    hold_pc = 32'h0;
    hold_instr = 32'h0;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
`ifdef IFU_MISALIGN_TRAP_EN
      redirect_pc    = $urandom() & 32'hFFFF_FFFC;
`else
      redirect_pc    = $urandom();
`endif
      #1;
      if (hold_pending) begin
        chk1("rnd_hold_valid", if_valid, 1'b1);
        chk32("rnd_hold_pc", if_pc, hold_pc);
        chk32("rnd_hold_instr", if_instr, hold_instr);
      end
      if (if_valid && !if_ready) chk1("rnd_stall_req", imem_req, 1'b0);
      hold_pending = if_valid && !if_ready && !redirect_valid;
      hold_pc = if_pc;
      hold_instr = if_instr;
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back({redirect_pc[31:2], 2'b00});
      end else if (if_valid && if_ready) begin
        exp_pc_v = exp_q.pop_front();
        chk32("rnd_pc", if_pc, exp_pc_v);
        chk32("rnd_instr", if_instr, exp_pc_v ^ XORPAT);
        exp_q.push_back(exp_pc_v + 32'd4);
        accepts++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    chk1("rnd_progress", accepts > 500, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
